// File: rtl/output_vc_credit_manager_pkg.sv
// ----------------------------------------------------------------------------
// output_vc_credit_manager_pkg
// Shared types and default sizing for the output VC credit manager.
//   DEF_PORT_NUM     router ports feeding this output (requesters per VC)
//   DEF_VC_NUM       virtual channels per port
//   DEF_BUFFER_SIZE  downstream per-VC buffer depth in flits (initial credits)
//   VC_IDX_W         width of an output VC index, never below 1
//   vc_state_t       per-output-VC lifecycle state
// ----------------------------------------------------------------------------
package output_vc_credit_manager_pkg;

    localparam int DEF_PORT_NUM    = 5;
    localparam int DEF_VC_NUM      = 2;
    localparam int DEF_BUFFER_SIZE = 8;

    // Index width that stays usable when there is only one item to index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VC_IDX_W = idx_w(DEF_VC_NUM);

    typedef enum logic [1:0] {
        VC_IDLE     = 2'd0,
        VC_ACTIVE   = 2'd1,
        VC_DRAINING = 2'd2
    } vc_state_t;

endpackage

// File: rtl/output_vc_credit_manager_if.sv
// ----------------------------------------------------------------------------
// output_vc_credit_manager_if
// Bundle between route computation / switch allocator / link (master side)
// and the output VC credit manager (slave side).
//   va_request_i      [PORT_NUM][VC_NUM]  input VC asks for an output VC
//   va_grant_o        [PORT_NUM][VC_NUM]  one-hot or zero allocation grant
//   va_out_vc_o       VC index handed to the granted requester
//   flit_sent_i / flit_sent_vc_i / flit_sent_tail_i  flit left on an output VC
//   credit_i / credit_vc_i                           downstream credit return
//   can_send_o        [VC_NUM]  VC active with credit available
//   vc_idle_o         [VC_NUM]  VC unallocated
//   error_o           sticky protocol error
// ----------------------------------------------------------------------------
interface output_vc_credit_manager_if
    import output_vc_credit_manager_pkg::*;
#(
    parameter int PORT_NUM = DEF_PORT_NUM,
    parameter int VC_NUM   = DEF_VC_NUM,
    parameter int VW       = idx_w(VC_NUM)
);
    logic [PORT_NUM-1:0][VC_NUM-1:0] va_request_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0] va_grant_o;
    logic [VW-1:0]                   va_out_vc_o;
    logic                            flit_sent_i;
    logic [VW-1:0]                   flit_sent_vc_i;
    logic                            flit_sent_tail_i;
    logic                            credit_i;
    logic [VW-1:0]                   credit_vc_i;
    logic [VC_NUM-1:0]               can_send_o;
    logic [VC_NUM-1:0]               vc_idle_o;
    logic                            error_o;

    modport master (
        output va_request_i, flit_sent_i, flit_sent_vc_i, flit_sent_tail_i,
               credit_i, credit_vc_i,
        input  va_grant_o, va_out_vc_o, can_send_o, vc_idle_o, error_o
    );

    modport slave (
        input  va_request_i, flit_sent_i, flit_sent_vc_i, flit_sent_tail_i,
               credit_i, credit_vc_i,
        output va_grant_o, va_out_vc_o, can_send_o, vc_idle_o, error_o
    );

endinterface

// File: rtl/output_vc_credit_manager_arbiter.sv
// ----------------------------------------------------------------------------
// round_robin_arbiter
// Combinational round-robin grant over AGENTS_NUM requesters; the search
// starts at the pointer, which moves past the winner only when a grant is
// issued.
//   clk, rst   clock, asynchronous active-low reset (pointer -> 0)
//   req_i      request vector
//   grant_o    one-hot grant, zero when nothing is requested
// ----------------------------------------------------------------------------
module round_robin_arbiter
    import output_vc_credit_manager_pkg::*;
#(
    parameter int AGENTS_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] req_i,
    output logic [AGENTS_NUM-1:0] grant_o
);
    localparam int IDX_W = idx_w(AGENTS_NUM);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx, cidx;
    logic             found;
    int               cand;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        gidx    = '0;
        cidx    = '0;
        cand    = 0;
        for (int k = 0; k < AGENTS_NUM; k++) begin
            // Rotated search index, wrapped without a modulo operator.
            cand = int'(ptr_q) + k;
            if (cand >= AGENTS_NUM) cand = cand - AGENTS_NUM;
            cidx = IDX_W'(cand);
            if (!found && req_i[cidx]) begin
                found = 1'b1;
                gidx  = cidx;
            end
        end
        if (found) grant_o[gidx] = 1'b1;

        ptr_d = ptr_q;
        if (found) ptr_d = (gidx == IDX_W'(AGENTS_NUM - 1)) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/output_vc_credit_manager.sv
// ----------------------------------------------------------------------------
// output_vc_credit_manager
// Owns the downstream VCs of one router output port: hands free VCs to
// requesting input VCs, tracks per-VC credits and releases a VC once its
// tail has left and the downstream buffer has fully drained.
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   slave side of output_vc_credit_manager_if (requests, grants,
//         sent flits, credit returns, can_send/idle status, sticky error)
// ----------------------------------------------------------------------------
module output_vc_credit_manager
    import output_vc_credit_manager_pkg::*;
#(
    parameter int PORT_NUM    = DEF_PORT_NUM,
    parameter int VC_NUM      = DEF_VC_NUM,
    parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    output_vc_credit_manager_if.slave   bus
);
    localparam int AGENTS = PORT_NUM * VC_NUM;
    localparam int VW     = idx_w(VC_NUM);
    localparam int CRED_W = $clog2(BUFFER_SIZE + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUFFER_SIZE);

    vc_state_t                      state_q [VC_NUM];
    vc_state_t                      state_d [VC_NUM];
    logic [VC_NUM-1:0][CRED_W-1:0]  cred_q, cred_d;
    logic                           err_q, err_d;

    logic [VC_NUM-1:0] idle, act_ok, snd, crd;
    logic              any_idle, alloc;
    logic [VW-1:0]     free_vc;
    logic [AGENTS-1:0] arb_req, arb_grant;

    // Per-VC decode of registered state and of this cycle's send/credit.
    always_comb begin
        idle   = '0;
        act_ok = '0;
        snd    = '0;
        crd    = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            idle[v]   = (state_q[v] == VC_IDLE);
            act_ok[v] = (state_q[v] == VC_ACTIVE) && (cred_q[v] != '0);
            snd[v]    = bus.flit_sent_i && (bus.flit_sent_vc_i == VW'(v));
            crd[v]    = bus.credit_i    && (bus.credit_vc_i    == VW'(v));
        end
    end

    // Lowest-index idle VC is the one handed out.
    always_comb begin
        free_vc = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (idle[v]) free_vc = VW'(v);
        end
    end

    assign any_idle = |idle;

    // With no idle VC the arbiter sees nothing, so its pointer holds.
    // Allocation is also held off while reset is asserted.
    assign arb_req = (any_idle && rst) ? bus.va_request_i : '0;

    round_robin_arbiter #(
        .AGENTS_NUM (AGENTS)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (arb_req),
        .grant_o (arb_grant)
    );

    assign alloc = |arb_grant;

    always_comb begin
        err_d = err_q;
        for (int v = 0; v < VC_NUM; v++) begin
            state_d[v] = state_q[v];
            cred_d[v]  = cred_q[v];

            unique case (state_q[v])
                VC_IDLE:     if (alloc && free_vc == VW'(v)) state_d[v] = VC_ACTIVE;
                VC_ACTIVE:   if (snd[v] && bus.flit_sent_tail_i) state_d[v] = VC_DRAINING;
                // Judged on the registered count, so release lags the last
                // credit by one cycle.
                VC_DRAINING: if (cred_q[v] == CRED_MAX) state_d[v] = VC_IDLE;
                default:     state_d[v] = VC_IDLE;
            endcase

            if (snd[v] && state_q[v] == VC_IDLE) err_d = 1'b1;

            // Send and credit on the same VC cancel out.
            if (snd[v] && !crd[v]) begin
                if (cred_q[v] == '0) err_d = 1'b1;
                else                 cred_d[v] = cred_q[v] - 1'b1;
            end else if (crd[v] && !snd[v]) begin
                if (cred_q[v] == CRED_MAX) err_d = 1'b1;
                else                       cred_d[v] = cred_q[v] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= VC_IDLE;
                cred_q[v]  <= CRED_MAX;
            end
            err_q <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
                cred_q[v]  <= cred_d[v];
            end
            err_q <= err_d;
        end
    end

    assign bus.va_grant_o  = arb_grant;
    assign bus.va_out_vc_o = free_vc;
    assign bus.can_send_o  = act_ok;
    assign bus.vc_idle_o   = idle;
    assign bus.error_o     = err_q;

endmodule

// File: tb/tb_output_vc_credit_manager.sv
module tb_output_vc_credit_manager;
    localparam int PN = 5;
    localparam int VN = 2;
    localparam int BS = 4;
    localparam int NA = PN * VN;
    localparam int VW = 1;
    localparam int S_IDLE = 0;
    localparam int S_ACT  = 1;
    localparam int S_DRN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    output_vc_credit_manager_if #(.PORT_NUM(PN), .VC_NUM(VN)) bus ();

    output_vc_credit_manager #(
        .PORT_NUM    (PN),
        .VC_NUM      (VN),
        .BUFFER_SIZE (BS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: VC lifecycle, credit counts, arbiter pointer, sticky error.
    int m_state [VN];
    int m_cred  [VN];
    int m_ptr;
    bit m_err;
    int last_g;

    logic [NA-1:0] act_grant;
    logic [VW-1:0] act_vc;

    function automatic int m_pick(input logic [NA-1:0] r);
        bit any = 0;
        for (int v = 0; v < VN; v++) if (m_state[v] == S_IDLE) any = 1;
        if (!any) return -1;
        for (int k = 0; k < NA; k++) begin
            int i = (m_ptr + k) % NA;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int m_free();
        for (int v = 0; v < VN; v++) if (m_state[v] == S_IDLE) return v;
        return 0;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VN; v++) begin
            m_state[v] = S_IDLE;
            m_cred[v]  = BS;
        end
        m_ptr  = 0;
        m_err  = 0;
        last_g = -1;
    endtask

    task automatic drive(input bit s, input int sv, input bit t, input bit c, input int cv);
        bus.flit_sent_i      = s;
        bus.flit_sent_vc_i   = VW'(sv);
        bus.flit_sent_tail_i = t;
        bus.credit_i         = c;
        bus.credit_vc_i      = VW'(cv);
    endtask

    // One clock: compare every output against the model mid low phase,
    // then advance the model across the rising edge. Entered/left at negedge.
    task automatic step();
        logic [NA-1:0] r, exp_g;
        logic [VN-1:0] exp_idle, exp_can;
        int g, fv, sv, cv, d, nc;
        bit s, t, c;
        int ns [VN];
        #2;
        r  = bus.va_request_i;
        g  = m_pick(r);
        fv = m_free();
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        for (int v = 0; v < VN; v++) begin
            exp_idle[v] = (m_state[v] == S_IDLE);
            exp_can[v]  = (m_state[v] == S_ACT) && (m_cred[v] > 0);
        end
        act_grant = bus.va_grant_o;
        act_vc    = bus.va_out_vc_o;
        checks++;
        if (act_grant !== exp_g) begin
            errors++;
            $display("FAIL grant t=%0t got %b exp %b", $time, act_grant, exp_g);
        end
        if (exp_idle != '0) begin
            checks++;
            if (act_vc !== VW'(fv)) begin
                errors++;
                $display("FAIL out_vc t=%0t got %0d exp %0d", $time, act_vc, fv);
            end
        end
        checks++;
        if (bus.vc_idle_o !== exp_idle) begin
            errors++;
            $display("FAIL vc_idle t=%0t got %b exp %b", $time, bus.vc_idle_o, exp_idle);
        end
        checks++;
        if (bus.can_send_o !== exp_can) begin
            errors++;
            $display("FAIL can_send t=%0t got %b exp %b", $time, bus.can_send_o, exp_can);
        end
        checks++;
        if (bus.error_o !== m_err) begin
            errors++;
            $display("FAIL error t=%0t got %b exp %b", $time, bus.error_o, m_err);
        end
        s  = bus.flit_sent_i;
        sv = int'(bus.flit_sent_vc_i);
        t  = bus.flit_sent_tail_i;
        c  = bus.credit_i;
        cv = int'(bus.credit_vc_i);
        @(posedge clk);
        for (int v = 0; v < VN; v++) begin
            ns[v] = m_state[v];
            if (m_state[v] == S_ACT && s && sv == v && t) ns[v] = S_DRN;
            if (m_state[v] == S_DRN && m_cred[v] == BS)   ns[v] = S_IDLE;
        end
        if (g >= 0) begin
            ns[fv] = S_ACT;
            m_ptr  = (g + 1) % NA;
        end
        for (int v = 0; v < VN; v++) begin
            d = 0;
            if (s && sv == v) begin
                d = d - 1;
                if (m_state[v] == S_IDLE) m_err = 1;
            end
            if (c && cv == v) d = d + 1;
            nc = m_cred[v] + d;
            if (nc < 0)  begin m_err = 1; nc = 0;  end
            if (nc > BS) begin m_err = 1; nc = BS; end
            m_cred[v] = nc;
        end
        for (int v = 0; v < VN; v++) m_state[v] = ns[v];
        last_g = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.va_request_i = '0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.va_request_i = '0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.vc_idle_o !== 2'b11) begin
            errors++;
            $display("FAIL rst_hold_idle got %b exp 11", bus.vc_idle_o);
        end
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.vc_idle_o !== 2'b11) begin
            errors++;
            $display("FAIL rst_idle got %b exp 11", bus.vc_idle_o);
        end
        checks++;
        if (bus.can_send_o !== 2'b00) begin
            errors++;
            $display("FAIL rst_can_send got %b exp 00", bus.can_send_o);
        end
        checks++;
        if (bus.va_grant_o !== '0) begin
            errors++;
            $display("FAIL rst_grant got %b exp 0", bus.va_grant_o);
        end
        checks++;
        if (bus.error_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_error got %b exp 0", bus.error_o);
        end
    endtask

    task automatic test_alloc();
        bus.va_request_i = '0;
        bus.va_request_i[0][0] = 1'b1;
        bus.va_request_i[1][1] = 1'b1;
        bus.va_request_i[2][0] = 1'b1;
        step();
        checks++;
        if (act_grant !== 10'b00000_00001 || act_vc !== 1'b0) begin
            errors++;
            $display("FAIL alloc_c1 got %b/%0d exp 0000000001/0", act_grant, act_vc);
        end
        bus.va_request_i[0][0] = 1'b0;
        step();
        checks++;
        if (act_grant !== 10'b00000_01000 || act_vc !== 1'b1) begin
            errors++;
            $display("FAIL alloc_c2 got %b/%0d exp 0000001000/1", act_grant, act_vc);
        end
        bus.va_request_i[1][1] = 1'b0;
        step();
        checks++;
        if (act_grant !== '0) begin
            errors++;
            $display("FAIL alloc_c3 got %b exp 0", act_grant);
        end
    endtask

    task automatic test_credit_exhaust();
        // (2,0) stays requested throughout; it is served once VC0 frees.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.can_send_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL exhaust_can_before_%0d got %b exp 1", i, bus.can_send_o[0]);
            end
            drive(1, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.can_send_o[0] !== 1'b0 || bus.error_o !== 1'b0) begin
            errors++;
            $display("FAIL exhaust_after4 got can=%b err=%b exp 0/0", bus.can_send_o[0], bus.error_o);
        end
        drive(1, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.error_o !== 1'b1) begin
            errors++;
            $display("FAIL underflow_err got %b exp 1", bus.error_o);
        end
        repeat (3) begin
            drive(0, 0, 0, 1, 0);
            step();
        end
        drive(1, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 1, 0);
        step();
        checks++;
        if (bus.vc_idle_o[0] !== 1'b0 || bus.can_send_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL drain_1cred got idle=%b can=%b exp 0/0", bus.vc_idle_o[0], bus.can_send_o[0]);
        end
        drive(0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.vc_idle_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL drain_full_same got %b exp 0", bus.vc_idle_o[0]);
        end
        bus.va_request_i[0][0] = 1'b1;
        step();
        checks++;
        if (act_grant !== '0 || bus.vc_idle_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL release got grant=%b idle=%b exp 0/1", act_grant, bus.vc_idle_o[0]);
        end
        step();
        checks++;
        if (act_grant !== 10'b00000_10000 || act_vc !== 1'b0) begin
            errors++;
            $display("FAIL realloc_ptr got %b/%0d exp 0000010000/0", act_grant, act_vc);
        end
        bus.va_request_i[2][0] = 1'b0;
        step();
        checks++;
        if (act_grant !== '0) begin
            errors++;
            $display("FAIL realloc_full got %b exp 0", act_grant);
        end
        bus.va_request_i = '0;
    endtask

    task automatic test_same_cycle();
        int n;
        drive(1, 1, 0, 0, 0);
        step();
        drive(1, 1, 0, 1, 1);
        step();
        drive(1, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        n = 0;
        while (bus.can_send_o[1] && n < 8) begin
            drive(1, 1, 0, 0, 0);
            step();
            n++;
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL same_cycle_vc1_credits got %0d exp 4", n);
        end
        n = 0;
        while (bus.can_send_o[0] && n < 8) begin
            drive(1, 0, 0, 0, 0);
            step();
            n++;
        end
        drive(0, 0, 0, 0, 0);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL same_cycle_vc0_credits got %0d exp 3", n);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 1, 0);
        step();
        drive(1, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        bus.va_request_i[1][0] = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.vc_idle_o !== 2'b11 || bus.can_send_o !== 2'b00) begin
            errors++;
            $display("FAIL midrst_state got idle=%b can=%b exp 11/00", bus.vc_idle_o, bus.can_send_o);
        end
        checks++;
        if (bus.va_grant_o !== '0) begin
            errors++;
            $display("FAIL midrst_grant got %b exp 0", bus.va_grant_o);
        end
        checks++;
        if (bus.error_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_error got %b exp 0", bus.error_o);
        end
        @(negedge clk);
        bus.va_request_i = '0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_errors();
        do_reset();
        drive(1, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.error_o !== 1'b1) begin
            errors++;
            $display("FAIL err_send_idle got %b exp 1", bus.error_o);
        end
        do_reset();
        drive(0, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.error_o !== 1'b1) begin
            errors++;
            $display("FAIL err_overflow got %b exp 1", bus.error_o);
        end
        step();
    endtask

    task automatic test_random();
        logic [NA-1:0] r;
        int v, c;
        bit s, t, cr;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            r = NA'($urandom);
            if (last_g >= 0) r[last_g] = 1'b0;
            bus.va_request_i = r;
            v = int'($urandom_range(VN - 1));
            s = (m_state[v] == S_ACT) && (m_cred[v] > 0) && ($urandom_range(1) == 1);
            t = ($urandom_range(3) == 0);
            c = int'($urandom_range(VN - 1));
            cr = (m_cred[c] < BS) && ($urandom_range(1) == 1);
            drive(s, v, t, cr, c);
            step();
        end
        bus.va_request_i = '0;
        drive(0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        bus.va_request_i = '0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_alloc();
        test_credit_exhaust();
        test_same_cycle();
        test_reset_mid();
        test_errors();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
